// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : univ_shift_reg
//  Purpose  : Universal shift register (hold / shift R / shift L / load) with
//             synchronous preset and a frame counter that pulses full every
//             WIDTH shifts, for serial-to-parallel capture downstream.
//  Revision : 1.0  initial release
// ============================================================================
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pre,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             full
);

  localparam logic [1:0]    c_MODE_HOLD  = 2'b00;
  localparam logic [1:0]    c_MODE_RIGHT = 2'b01;
  localparam logic [1:0]    c_MODE_LEFT  = 2'b10;
  localparam logic [1:0]    c_MODE_LOAD  = 2'b11;
  localparam logic [CW-1:0] c_CNT_MAX    = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_full;

  logic             w_wrap;
  logic [CW-1:0]    w_cnt_next;

  // Both shift directions advance the same frame counter.
  assign w_wrap     = (r_cnt == c_CNT_MAX);
  assign w_cnt_next = w_wrap ? '0 : r_cnt + CW'(1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q    <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else if (pre) begin
      r_q    <= '1;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      case (mode)
        c_MODE_HOLD: begin
          r_full <= 1'b0;
        end
        c_MODE_RIGHT: begin
          r_q    <= {sin_r, r_q[WIDTH-1:1]};
          r_cnt  <= w_cnt_next;
          r_full <= w_wrap;
        end
        c_MODE_LEFT: begin
          r_q    <= {r_q[WIDTH-2:0], sin_l};
          r_cnt  <= w_cnt_next;
          r_full <= w_wrap;
        end
        c_MODE_LOAD: begin
          r_q    <= pin;
          r_cnt  <= '0;
          r_full <= 1'b0;
        end
        default: begin
          r_full <= 1'b0;
        end
      endcase
    end
  end

  assign q      = r_q;
  assign cnt    = r_cnt;
  assign full   = r_full;
  assign sout_r = r_q[0];
  assign sout_l = r_q[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_univ_shift_reg
//  Purpose  : Self-checking bench for univ_shift_reg against an arithmetic
//             reference model, with directed and randomized stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_univ_shift_reg;

  localparam int W  = 4;
  localparam int CW = $clog2(W);
  localparam int c_MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          pre = 1'b0;
  logic [1:0]    mode = 2'b11;
  logic          sin_r = 1'b0;
  logic          sin_l = 1'b0;
  logic [W-1:0]  pin = 4'b1010;
  logic [W-1:0]  q;
  logic          sout_r;
  logic          sout_l;
  logic [CW-1:0] cnt;
  logic          full;

  int n_checks = 0;
  int n_errors = 0;

  univ_shift_reg #(.WIDTH(W), .CW(CW)) dut (
    .clk    (clk),
    .clr    (clr),
    .pre    (pre),
    .mode   (mode),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .pin    (pin),
    .q      (q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .cnt    (cnt),
    .full   (full)
  );

  always #5 clk = ~clk;

  // Reference model: register as an integer, frame progress as a shift tally.
  int m_q      = 0;
  int m_shifts = 0;
  int m_full   = 0;

  task automatic model_shift();
    m_shifts = m_shifts + 1;
    if (m_shifts == W) begin
      m_shifts = 0;
      m_full   = 1;
    end else begin
      m_full = 0;
    end
  endtask

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_q = 0; m_shifts = 0; m_full = 0;
    end else if (pre) begin
      m_q = c_MASK; m_shifts = 0; m_full = 0;
    end else begin
      case (mode)
        2'd0: m_full = 0;
        2'd1: begin
          m_q = (m_q >> 1) | (int'(sin_r) << (W - 1));
          model_shift();
        end
        2'd2: begin
          m_q = ((m_q << 1) | int'(sin_l)) & c_MASK;
          model_shift();
        end
        default: begin
          m_q = int'(pin); m_shifts = 0; m_full = 0;
        end
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("q",      int'(q),      m_q);
    chk("cnt",    int'(cnt),    m_shifts);
    chk("full",   int'(full),   m_full);
    chk("sout_r", int'(sout_r), m_q & 1);
    chk("sout_l", int'(sout_l), (m_q >> (W - 1)) & 1);
  end

  // Apply inputs, let one rising edge sample them, return after the negedge.
  task automatic step(input logic p, input logic [1:0] m, input logic sr,
                      input logic sl, input logic [W-1:0] pi);
    pre = p; mode = m; sin_r = sr; sin_l = sl; pin = pi;
    @(negedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    #1;
    chk("clr_async_q",    int'(q),    0);
    chk("clr_async_cnt",  int'(cnt),  0);
    chk("clr_async_full", int'(full), 0);
    #1;
    clr = 1'b0;
  endtask

  logic [3:0] sr_seq;
  int         pulses;

  initial begin
    // Reset asserted from time zero with load mode and data on the inputs.
    #1;
    chk("rst_q",    int'(q),    0);
    chk("rst_cnt",  int'(cnt),  0);
    chk("rst_full", int'(full), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hold_q", int'(q), 0);
    clr = 1'b0;

    // Right-shift frame: 1,0,1,1 enter at the MSB.
    sr_seq = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b01, sr_seq[i], 1'b0, '0);
      chk("rframe_cnt", int'(cnt), (i + 1) % 4);
      chk("rframe_full", int'(full), (i == 3) ? 1 : 0);
    end
    chk("rframe_q", int'(q), 4'b1101);
    step(1'b0, 2'b00, 1'b0, 1'b0, '0);
    chk("rframe_full_drop", int'(full), 0);

    // Left-shift frame after loading 0001.
    step(1'b0, 2'b11, 1'b0, 1'b0, 4'b0001);
    chk("lload_cnt", int'(cnt), 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b10, 1'b0, 1'b0, '0);
      chk("lframe_q", int'(q), (2 << i) & c_MASK);
      chk("lframe_full", int'(full), (i == 3) ? 1 : 0);
    end

    // Load in mid-frame discards the partial frame.
    step(1'b0, 2'b01, 1'b1, 1'b0, '0);
    step(1'b0, 2'b01, 1'b1, 1'b0, '0);
    step(1'b0, 2'b11, 1'b0, 1'b0, 4'b0110);
    chk("midload_q", int'(q), 4'b0110);
    chk("midload_cnt", int'(cnt), 0);
    chk("midload_full", int'(full), 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b10, 1'b0, 1'b1, '0);
      chk("midload_refull", int'(full), (i == 3) ? 1 : 0);
    end

    // Preset beats shift mode.
    step(1'b1, 2'b01, 1'b0, 1'b0, '0);
    chk("pre_q", int'(q), 4'b1111);
    chk("pre_cnt", int'(cnt), 0);
    step(1'b0, 2'b00, 1'b0, 1'b0, '0);
    chk("pre_hold_q", int'(q), 4'b1111);

    // Clear between edges after three shifts, then two clean frames.
    for (int i = 0; i < 3; i++) step(1'b0, 2'b01, 1'b1, 1'b0, '0);
    clr_pulse();
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 2'b01, 1'b0, 1'b0, '0);
      if (full) pulses = pulses | (1 << i);
    end
    chk("clr_frame_pulses", pulses, (1 << 4) | (1 << 8));

    // Randomized traffic checked each cycle by the compare process.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) clr_pulse();
      step(($urandom_range(0, 15) == 0), 2'($urandom), 1'($urandom),
           1'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
